hls_ram_responder: RTL

- Memory-side responder for the array argument ports (arg_N_*) that HLS-generated kernels drive.
- Provides one registered read port, one write port and a debug read/write port used by testbenches.
- Zero-clears its contents after reset and on request, so a histogram-style kernel starts from empty bins.
- Sits outside the kernel wrapper, one instance per array argument.

---
 rtl/hls_ram_pkg.sv | 17 +
 rtl/hls_ram_clear_seq.sv | 63 ++++++
 rtl/hls_ram_responder.sv | 92 +++++++++
 3 files changed

// File: rtl/hls_ram_pkg.sv
// Shared types and helpers for the HLS array-argument RAM responder.
// The optional write-first forwarding is selected by HLS_RAM_WRITE_FORWARD_EN in the top.
package hls_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    // Value returned by any read whose address lies beyond the array.
    localparam int unsigned OOR_READ_VALUE = 0;

    function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/hls_ram_clear_seq.sv
// Zero-clear sequencer: sweeps every word once after reset or on request,
// holding the array busy until the last address has been written.
module hls_ram_clear_seq
    import hls_ram_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_start_i,
    output logic                  init_busy_o,
    output logic                  clr_we_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o,
    output ram_state_e            state_o
);

    // One extra bit so the counter cannot wrap when DEPTH == 2**ADDR_WIDTH.
    localparam int             CW   = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]  LAST = CW'(DEPTH - 1);

    ram_state_e    state_q;
    logic [CW-1:0] clr_cnt_q;
    logic          busy_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_cnt_q == LAST) begin
                        state_q   <= READY;
                        busy_q    <= 1'b0;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + CW'(1);
                    end
                end
                READY: begin
                    if (clear_start_i) begin
                        state_q   <= CLEAR;
                        busy_q    <= 1'b1;
                        clr_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q   <= CLEAR;
                    busy_q    <= 1'b1;
                    clr_cnt_q <= '0;
                end
            endcase
        end
    end

    assign init_busy_o = busy_q;
    assign clr_we_o    = (state_q == CLEAR);
    assign clr_addr_o  = clr_cnt_q[ADDR_WIDTH-1:0];
    assign state_o     = state_q;

endmodule

// File: rtl/hls_ram_responder.sv
// Memory-side responder for one HLS array argument: registered kernel and debug
// read ports, kernel and debug write ports, zero-clear; HLS_RAM_WRITE_FORWARD_EN selects write-first reads.
module hls_ram_responder
    import hls_ram_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] raddr_0,
    output logic [WIDTH-1:0]      rdata_0,
    input  logic [ADDR_WIDTH-1:0] waddr_0,
    input  logic [WIDTH-1:0]      wdata_0,
    input  logic                  wen_0,
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [WIDTH-1:0]      debug_data,
    input  logic [ADDR_WIDTH-1:0] debug_write_addr,
    input  logic [WIDTH-1:0]      debug_write_data,
    input  logic                  debug_write_en,
    input  logic                  clear_start,
    output logic                  init_busy
);

    ram_state_e            state;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    hls_ram_clear_seq #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clk           (clk),
        .rst           (rst),
        .clear_start_i (clear_start),
        .init_busy_o   (init_busy),
        .clr_we_o      (clr_we),
        .clr_addr_o    (clr_addr),
        .state_o       (state)
    );

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             kwr_ok;
    logic             dwr_ok;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] debug_data_q, debug_data_d;

    assign kwr_ok = wen_0 && in_range(32'(waddr_0), DEPTH);
    assign dwr_ok = debug_write_en && in_range(32'(debug_write_addr), DEPTH);

    // The array has no reset; the clear sweep owns it while busy. Kernel write lands last so it wins.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else begin
            if (dwr_ok) mem_q[debug_write_addr] <= debug_write_data;
            if (kwr_ok) mem_q[waddr_0] <= wdata_0;
        end
    end

    always_comb begin
        rdata_d      = WIDTH'(OOR_READ_VALUE);
        debug_data_d = WIDTH'(OOR_READ_VALUE);
        if (state == READY) begin
            if (in_range(32'(raddr_0), DEPTH))    rdata_d      = mem_q[raddr_0];
            if (in_range(32'(debug_addr), DEPTH)) debug_data_d = mem_q[debug_addr];
`ifdef HLS_RAM_WRITE_FORWARD_EN
            if (dwr_ok && (debug_write_addr == raddr_0))    rdata_d      = debug_write_data;
            if (kwr_ok && (waddr_0 == raddr_0))             rdata_d      = wdata_0;
            if (dwr_ok && (debug_write_addr == debug_addr)) debug_data_d = debug_write_data;
            if (kwr_ok && (waddr_0 == debug_addr))          debug_data_d = wdata_0;
`else
            // Read-first: the array holds the pre-write value during this cycle.
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q      <= '0;
            debug_data_q <= '0;
        end else begin
            rdata_q      <= rdata_d;
            debug_data_q <= debug_data_d;
        end
    end

    assign rdata_0    = rdata_q;
    assign debug_data = debug_data_q;

endmodule
